// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and frame constants for the buffered UART transmitter
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;
  localparam int UART_FRAME_DATA_BITS = 8;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: first-word fall-through byte FIFO with a separate occupancy counter
module uart_tx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic do_push, do_pop;
  assign full = level == (AW+1)'(DEPTH);
  assign empty = level == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign pop_data = mem[rptr];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop) rptr <= rptr + AW'(1);
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wptr] <= push_data;
endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: FIFO-buffered 8N1 UART transmitter; define UART_TX_PARITY_EN for 8E1 frames
module uart_tx_buffered import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          busy,
  output logic                          overflow,
  output logic                          uart_tx
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(UART_FRAME_DATA_BITS);
  uart_tx_state_t state, next_state;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bit_idx;
  logic [7:0] shift, shift_d, head;
  logic empty, pop, bit_end, last_bit, tx_d;
  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(wr_en),
    .push_data(wr_data),
    .pop(pop),
    .pop_data(head),
    .full(full),
    .empty(empty),
    .level(level)
  );
  assign bit_end = cnt == CW'(CLKS_PER_BIT - 1);
  assign last_bit = bit_idx == BW'(UART_FRAME_DATA_BITS - 1);
  assign busy = state != IDLE || !empty;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next_state;
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = empty ? IDLE : START;
      START:   next_state = bit_end ? DATA : START;
`ifdef UART_TX_PARITY_EN
      DATA:    next_state = bit_end && last_bit ? PARITY : DATA;
      PARITY:  next_state = bit_end ? STOP : PARITY;
`else
      DATA:    next_state = bit_end && last_bit ? STOP : DATA;
`endif
      STOP:    next_state = !bit_end ? STOP : empty ? IDLE : START;
      default: next_state = IDLE;
    endcase
  end
`ifdef UART_TX_PARITY_EN
  logic par, par_d;
  assign par_d = pop ? ^head : par;
  always_ff @(posedge clk or posedge rst)
    if (rst) par <= 1'b0;
    else par <= par_d;
`endif
  // the line register is loaded with the level of the state being entered, so tx tracks state without lag
  always_comb begin
    pop = !empty && (state == IDLE || (state == STOP && bit_end));
    shift_d = pop ? head : (state == DATA && bit_end) ? shift >> 1 : shift;
`ifdef UART_TX_PARITY_EN
    tx_d = next_state == START ? 1'b0 : next_state == DATA ? shift_d[0] : next_state == PARITY ? par_d : 1'b1;
`else
    tx_d = next_state == START ? 1'b0 : next_state == DATA ? shift_d[0] : 1'b1;
`endif
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      bit_idx <= '0;
      shift <= '0;
      uart_tx <= 1'b1;
      overflow <= 1'b0;
    end else begin
      cnt <= (bit_end || state == IDLE) ? '0 : cnt + CW'(1);
      bit_idx <= pop ? '0 : (state == DATA && bit_end) ? bit_idx + BW'(1) : bit_idx;
      shift <= shift_d;
      uart_tx <= tx_d;
      overflow <= overflow | (wr_en && full);
    end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: directed bench with a line decoder; CLKS_PER_BIT=4, FIFO_DEPTH=4
module tb_uart_tx_buffered;
  localparam int CPB = 4;
  localparam int DEP = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FR = CPB * NB;
  logic clk = 0, rst = 1, wr_en = 0;
  logic [7:0] wr_data = 0;
  logic full, busy, overflow, uart_tx;
  logic [2:0] level;
  int cyc = 0, total = 0, bad = 0, frame_err = 0, lvl_max = 0, w;
  logic m_on = 0, m_p = 0;
  logic [7:0] m_d = 0;
  int m_cnt = 0, m_t = 0, k;
  logic [7:0] rxq[$];
  logic rxp[$];
  int rxt[$];
  uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEP)) dut (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .full(full),
    .level(level),
    .busy(busy),
    .overflow(overflow),
    .uart_tx(uart_tx)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // line decoder: samples mid-bit, records byte, parity bit and first start-bit cycle
  always @(negedge clk) begin
    if (rst) m_on = 0;
    else begin
      if (int'(level) > lvl_max) lvl_max = int'(level);
      if (!m_on) begin
        if (!uart_tx) begin
          m_on = 1;
          m_cnt = 0;
          m_t = cyc;
        end
      end else begin
        m_cnt++;
        if (m_cnt % CPB == 2) begin
          k = m_cnt / CPB;
          if (k == 0) frame_err += int'(uart_tx);
          else if (k <= 8) m_d[k-1] = uart_tx;
          else if (k == 9 && NB == 11) m_p = uart_tx;
          else begin
            if (!uart_tx) frame_err++;
            rxq.push_back(m_d);
            rxp.push_back(m_p);
            rxt.push_back(m_t);
            m_on = 0;
          end
        end
      end
    end
  end
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic sync();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [7:0] d);
    wr_en = 1;
    wr_data = d;
    sync();
    wr_en = 0;
  endtask
  task automatic wait_cyc(input int c);
    do @(negedge clk); while (cyc < c);
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 3000 && busy !== 1'b0; i++) @(negedge clk);
    chk("idle_timeout", int'(busy), 0);
    repeat (4) @(negedge clk);
  endtask
  task automatic clear_rx();
    rxq.delete();
    rxp.delete();
    rxt.delete();
    lvl_max = 0;
  endtask
  task automatic chk_byte(input string tag, input int i, input int exp);
    chk(tag, i < rxq.size() ? int'(rxq[i]) : -1, exp);
  endtask
  initial begin
    logic [7:0] b3[3];
    b3[0] = 8'hA5; b3[1] = 8'h3C; b3[2] = 8'hFF;
    repeat (3) @(negedge clk);
    chk("rst_tx", int'(uart_tx), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ovf", int'(overflow), 0);
    sync();
    rst = 0;
    do sync(); while (cyc < 10);
    // single byte
    clear_rx();
    w = cyc;
    wr(8'h55);
    wait_cyc(w + 1);
    chk("t1_level1", int'(level), 1);
    chk("t1_tx_hi", int'(uart_tx), 1);
    chk("t1_busy", int'(busy), 1);
    wait_cyc(w + 2);
    chk("t1_tx_lo", int'(uart_tx), 0);
    chk("t1_level0", int'(level), 0);
    wait_cyc(w + FR + 1);
    chk("t1_busy_end", int'(busy), 1);
    wait_cyc(w + FR + 2);
    chk("t1_busy_drop", int'(busy), 0);
    repeat (2) @(negedge clk);
    chk("t1_frames", rxq.size(), 1);
    chk_byte("t1_byte", 0, 8'h55);
    chk("t1_latency", rxt.size() > 0 ? rxt[0] - w : -1, 2);
    // back-to-back
    sync();
    clear_rx();
    w = cyc;
    for (int i = 0; i < 3; i++) wr(b3[i]);
    wait_idle();
    chk("t2_lvl_peak", lvl_max, 2);
    chk("t2_frames", rxq.size(), 3);
    for (int i = 0; i < 3; i++) chk_byte("t2_byte", i, int'(b3[i]));
    chk("t2_start", rxt.size() > 0 ? rxt[0] - w : -1, 2);
    for (int i = 1; i < 3; i++) chk("t2_gap", rxt.size() > i ? rxt[i] - rxt[i-1] : -1, FR);
    // overflow
    sync();
    clear_rx();
    w = cyc;
    for (int i = 0; i < 6; i++) wr(8'h10 + 8'(i));
    wait_cyc(w + 6);
    chk("t3_level", int'(level), 4);
    chk("t3_full", int'(full), 1);
    chk("t3_ovf", int'(overflow), 1);
    wait_idle();
    repeat (60) @(negedge clk);
    chk("t3_frames", rxq.size(), 5);
    for (int i = 0; i < 5; i++) chk_byte("t3_byte", i, 8'h10 + i);
    chk("t3_ovf_sticky", int'(overflow), 1);
    chk("t3_full_after", int'(full), 0);
    // reset mid-frame during data bit 3 of 0x81
    sync();
    clear_rx();
    w = cyc;
    wr(8'h81);
    wr(8'h42);
    wr(8'h24);
    do sync(); while (cyc < w + 19);
    chk("t4_tx_bit3", int'(uart_tx), 0);
    chk("t4_level_pre", int'(level), 2);
    rst = 1;
    #1;
    chk("t4_tx", int'(uart_tx), 1);
    chk("t4_level", int'(level), 0);
    chk("t4_ovf", int'(overflow), 0);
    repeat (3) sync();
    rst = 0;
    repeat (120) @(negedge clk);
    chk("t4_frames", rxq.size(), 0);
    chk("t4_busy", int'(busy), 0);
    chk("t4_tx_idle", int'(uart_tx), 1);
    // wrap-around
    sync();
    clear_rx();
    for (int i = 0; i < 10; i++) begin
      wr(8'(i));
      if (i % 3 == 2) begin
        for (int j = 0; j < 500 && level != 0; j++) @(negedge clk);
        chk("t5_drain", int'(level), 0);
        sync();
      end
    end
    wait_idle();
    chk("t5_frames", rxq.size(), 10);
    for (int i = 0; i < 10; i++) chk_byte("t5_byte", i, i);
`ifdef UART_TX_PARITY_EN
    sync();
    clear_rx();
    wr(8'h07);
    wr(8'h03);
    wait_idle();
    chk("t6_frames", rxq.size(), 2);
    chk_byte("t6_byte0", 0, 8'h07);
    chk_byte("t6_byte1", 1, 8'h03);
    chk("t6_par0", rxp.size() > 0 ? int'(rxp[0]) : -1, 1);
    chk("t6_par1", rxp.size() > 1 ? int'(rxp[1]) : -1, 0);
    chk("t6_len", rxt.size() > 1 ? rxt[1] - rxt[0] : -1, 44);
`endif
    chk("frame_err", frame_err, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
